// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback
//   Last stage of the ECAP5-DPROC pipeline. It takes completed instructions
//   from the memory stage, aligns and extends load data, and shares the
//   single register-file write port between the pipeline and a debug writer.
//   All write-port, forwarding and debug-ack outputs are registered.
//
// Handshake: an instruction transfers on a rising clk_i edge when
//   input_valid_i & input_ready_o. input_ready_o depends only on the FSM
//   state (high in EMPTY), never on input_valid_i.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   input_valid_i/ready_o   memory-stage handshake
//   reg_write_i, reg_addr_i destination write flag and index
//   result_i                ALU/CSR result (non-load instructions)
//   load_*                  load size/sign/offset and raw bus word
//   dbg_write_i/addr/data   debug register write request
//   dbg_ack_o               one-cycle ack, aligned with the debug write
//   reg_write/waddr/wdata_o register-file write port
//   fwd_valid/addr/data_o   copies of the write port for decode bypass
//   instret_o               retired pipeline instruction count
//   held_o                  high while an accepted instruction waits (HELD)
//
// Build option: WRITEBACK_INSTRET_EN implements the 64-bit instret counter;
//   without it instret_o is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module writeback (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] result_i,
    input  logic        load_i,
    input  logic [1:0]  load_size_i,
    input  logic        load_unsigned_i,
    input  logic [1:0]  load_offset_i,
    input  logic [31:0] load_data_i,
    input  logic        dbg_write_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_data_i,
    output logic        dbg_ack_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o,
    output logic [63:0] instret_o,
    output logic        held_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e      state_q, state_d;

    // Hold buffer: instruction accepted in a cycle the debug write took the port.
    logic        hold_write_q, hold_write_d;
    logic [4:0]  hold_addr_q,  hold_addr_d;
    logic [31:0] hold_data_q,  hold_data_d;

    logic        reg_write_q, reg_write_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic        dbg_ack_q,   dbg_ack_d;

    logic        accept;
    logic        retire;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] sel_data;

    assign input_ready_o = (state_q == EMPTY);
    assign held_o        = (state_q == HELD);
    assign accept        = input_valid_i & input_ready_o;

    // Load alignment and extension.
    always_comb begin
        byte_lane = load_data_i[7:0];
        case (load_offset_i)
            2'd0:    byte_lane = load_data_i[7:0];
            2'd1:    byte_lane = load_data_i[15:8];
            2'd2:    byte_lane = load_data_i[23:16];
            default: byte_lane = load_data_i[31:24];
        endcase
        // Halfword lane uses only offset bit 1; bit 0 is ignored.
        half_lane = load_offset_i[1] ? load_data_i[31:16] : load_data_i[15:0];
        sel_data  = result_i;
        if (load_i) begin
            case (load_size_i)
                2'b00:   sel_data = {{24{~load_unsigned_i & byte_lane[7]}}, byte_lane};
                2'b01:   sel_data = {{16{~load_unsigned_i & half_lane[15]}}, half_lane};
                default: sel_data = load_data_i;
            endcase
        end
    end

    // Port arbitration: debug > held entry > newly accepted instruction.
    always_comb begin
        state_d     = state_q;
        hold_write_d = hold_write_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        reg_write_d = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        dbg_ack_d   = 1'b0;
        retire      = 1'b0;

        if (dbg_write_i) begin
            reg_write_d = (dbg_addr_i != 5'd0);
            reg_waddr_d = dbg_addr_i;
            reg_wdata_d = dbg_data_i;
            dbg_ack_d   = 1'b1;
            if (accept) begin
                hold_write_d = reg_write_i;
                hold_addr_d  = reg_addr_i;
                hold_data_d  = sel_data;
                state_d      = HELD;
            end
        end else if (state_q == HELD) begin
            reg_write_d = hold_write_q & (hold_addr_q != 5'd0);
            reg_waddr_d = hold_addr_q;
            reg_wdata_d = hold_data_q;
            retire      = 1'b1;
            state_d     = EMPTY;
        end else if (accept) begin
            reg_write_d = reg_write_i & (reg_addr_i != 5'd0);
            reg_waddr_d = reg_addr_i;
            reg_wdata_d = sel_data;
            retire      = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= EMPTY;
            hold_write_q <= 1'b0;
            hold_addr_q  <= 5'd0;
            hold_data_q  <= 32'd0;
            reg_write_q  <= 1'b0;
            reg_waddr_q  <= 5'd0;
            reg_wdata_q  <= 32'd0;
            dbg_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_write_q <= hold_write_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            reg_write_q  <= reg_write_d;
            reg_waddr_q  <= reg_waddr_d;
            reg_wdata_q  <= reg_wdata_d;
            dbg_ack_q    <= dbg_ack_d;
        end
    end

    assign reg_write_o = reg_write_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign fwd_valid_o = reg_write_q;
    assign fwd_addr_o  = reg_waddr_q;
    assign fwd_data_o  = reg_wdata_q;
    assign dbg_ack_o   = dbg_ack_q;

`ifdef WRITEBACK_INSTRET_EN
    // Counts on the edge that registers the instruction's write slot;
    // natural 64-bit wrap.
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + {63'd0, retire};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instret_q <= 64'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret_o     = 64'h0;
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

    logic        clk_i;
    logic        rst_i;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] result_i;
    logic        load_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [1:0]  load_offset_i;
    logic [31:0] load_data_i;
    logic        dbg_write_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_i;
    logic        dbg_ack_o;
    logic        reg_write_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
    logic [63:0] instret_o;
    logic        held_o;

    int n_checks = 0;
    int n_fail   = 0;

    writeback dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .input_valid_i   (input_valid_i),
        .input_ready_o   (input_ready_o),
        .reg_write_i     (reg_write_i),
        .reg_addr_i      (reg_addr_i),
        .result_i        (result_i),
        .load_i          (load_i),
        .load_size_i     (load_size_i),
        .load_unsigned_i (load_unsigned_i),
        .load_offset_i   (load_offset_i),
        .load_data_i     (load_data_i),
        .dbg_write_i     (dbg_write_i),
        .dbg_addr_i      (dbg_addr_i),
        .dbg_data_i      (dbg_data_i),
        .dbg_ack_o       (dbg_ack_o),
        .reg_write_o     (reg_write_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o),
        .fwd_valid_o     (fwd_valid_o),
        .fwd_addr_o      (fwd_addr_o),
        .fwd_data_o      (fwd_data_o),
        .instret_o       (instret_o),
        .held_o          (held_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ret_exp(input logic [63:0] n);
`ifdef WRITEBACK_INSTRET_EN
        return n;
`else
        return 64'h0 & n;
`endif
    endfunction

    // Data a completed instruction writes, from the extension rules.
    function automatic logic [31:0] model_data(input logic ld, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] off,
                                               input logic [31:0] ldata, input logic [31:0] res);
        logic [31:0] v;
        if (!ld) return res;
        if (sz == 2'd0) begin
            v = (ldata >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (ldata >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = ldata;
        end
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    // exp_q holds accepted instructions not yet written: {write, addr, data}.
    logic [37:0] exp_q[$];
    logic [37:0] m_e;
    logic        m_write;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [63:0] m_instret;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exp_q.delete();
            m_write   = 1'b0;
            m_waddr   = 5'd0;
            m_wdata   = 32'd0;
            m_ack     = 1'b0;
            m_instret = 64'd0;
        end else begin
            if (input_valid_i && exp_q.size() == 0)
                exp_q.push_back({reg_write_i, reg_addr_i,
                                 model_data(load_i, load_size_i, load_unsigned_i,
                                            load_offset_i, load_data_i, result_i)});
            if (dbg_write_i) begin
                m_write = (dbg_addr_i != 5'd0);
                m_waddr = dbg_addr_i;
                m_wdata = dbg_data_i;
                m_ack   = 1'b1;
            end else if (exp_q.size() > 0) begin
                m_e       = exp_q.pop_front();
                m_write   = m_e[37] && (m_e[36:32] != 5'd0);
                m_waddr   = m_e[36:32];
                m_wdata   = m_e[31:0];
                m_ack     = 1'b0;
                m_instret = m_instret + 64'd1;
            end else begin
                m_write = 1'b0;
                m_ack   = 1'b0;
            end
        end
    end

    // ---------------- scoreboard compare (every cycle out of reset) ----------------
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            check("reg_write", reg_write_o, m_write);
            check("reg_waddr", reg_waddr_o, m_waddr);
            check("reg_wdata", reg_wdata_o, m_wdata);
            check("fwd_valid", fwd_valid_o, m_write);
            check("fwd_addr",  fwd_addr_o,  m_waddr);
            check("fwd_data",  fwd_data_o,  m_wdata);
            check("dbg_ack",   dbg_ack_o,   m_ack);
            check("instret",   instret_o,   ret_exp(m_instret));
            check("ready",     input_ready_o, exp_q.size() == 0);
            check("held",      held_o,        exp_q.size() != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic v, input logic wr, input logic [4:0] a,
                             input logic [31:0] res, input logic ld, input logic [1:0] sz,
                             input logic uns, input logic [1:0] off, input logic [31:0] ldata);
        input_valid_i   = v;
        reg_write_i     = wr;
        reg_addr_i      = a;
        result_i        = res;
        load_i          = ld;
        load_size_i     = sz;
        load_unsigned_i = uns;
        load_offset_i   = off;
        load_data_i     = ldata;
    endtask

    task automatic set_dbg(input logic en, input logic [4:0] a, input logic [31:0] d);
        dbg_write_i = en;
        dbg_addr_i  = a;
        dbg_data_i  = d;
    endtask

    task automatic idle();
        set_instr(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0);
        set_dbg(1'b0, 5'd0, 32'd0);
    endtask

    task automatic load_check(input string name, input logic [1:0] sz, input logic uns,
                              input logic [1:0] off, input logic [31:0] exp);
        set_instr(1'b1, 1'b1, 5'd4, 32'h0, 1'b1, sz, uns, off, 32'h80FF7F01);
        @(negedge clk_i);
        idle();
        check(name, reg_wdata_o, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b0;
        idle();
        repeat (3) @(negedge clk_i);
        check("rst write",   reg_write_o, 1'b0);
        check("rst waddr",   reg_waddr_o, 5'd0);
        check("rst wdata",   reg_wdata_o, 32'd0);
        check("rst ack",     dbg_ack_o,   1'b0);
        check("rst instret", instret_o,   64'd0);
        check("rst ready",   input_ready_o, 1'b1);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        @(negedge clk_i);

        // Simple ALU write, one cycle latency
        set_instr(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        @(negedge clk_i);
        idle();
        check("alu write", reg_write_o, 1'b1);
        check("alu waddr", reg_waddr_o, 5'd5);
        check("alu wdata", reg_wdata_o, 32'hDEADBEEF);
        check("alu fwd",   fwd_data_o,  32'hDEADBEEF);
        check("alu instret", instret_o, ret_exp(64'd1));

        // Load alignment and extension
        load_check("lb off2",  2'd0, 1'b0, 2'd2, 32'hFFFFFFFF);
        load_check("lbu off3", 2'd0, 1'b1, 2'd3, 32'h00000080);
        load_check("lh off2",  2'd1, 1'b0, 2'd2, 32'hFFFF80FF);
        load_check("lh off1",  2'd1, 1'b0, 2'd1, 32'h00007F01);
        check("load instret", instret_o, ret_exp(64'd5));

        // Accept colliding with a debug write
        set_instr(1'b1, 1'b1, 5'd7, 32'd1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        set_dbg(1'b1, 5'd3, 32'd9);
        @(negedge clk_i);
        idle();
        check("coll dbg waddr", reg_waddr_o, 5'd3);
        check("coll dbg wdata", reg_wdata_o, 32'd9);
        check("coll dbg ack",   dbg_ack_o,   1'b1);
        check("coll ready0",    input_ready_o, 1'b0);
        check("coll instret0",  instret_o, ret_exp(64'd5));
        @(negedge clk_i);
        check("coll held waddr", reg_waddr_o, 5'd7);
        check("coll held wdata", reg_wdata_o, 32'd1);
        check("coll held write", reg_write_o, 1'b1);
        check("coll ready1",     input_ready_o, 1'b1);
        check("coll instret1",   instret_o, ret_exp(64'd6));

        // Debug held high for three more cycles while HELD
        set_instr(1'b1, 1'b1, 5'd10, 32'hA, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        set_dbg(1'b1, 5'd1, 32'h11);
        @(negedge clk_i);
        check("hold enter ack", dbg_ack_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 1'b1, 5'd12, 32'hBAD, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
            set_dbg(1'b1, 5'(2 + i), 32'h20 + 32'(i));
            @(negedge clk_i);
            check("hold dbg waddr", reg_waddr_o, 5'(2 + i));
            check("hold dbg ack",   dbg_ack_o,   1'b1);
            check("hold ready",     input_ready_o, 1'b0);
        end
        idle();
        @(negedge clk_i);
        check("hold out waddr", reg_waddr_o, 5'd10);
        check("hold out wdata", reg_wdata_o, 32'hA);
        check("hold out ack",   dbg_ack_o,   1'b0);
        check("hold instret",   instret_o, ret_exp(64'd7));
        @(negedge clk_i);
        check("no stray write", reg_write_o, 1'b0);

        // x0 writes
        set_instr(1'b1, 1'b1, 5'd0, 32'd5, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        @(negedge clk_i);
        idle();
        check("x0 pipe write", reg_write_o, 1'b0);
        check("x0 pipe wdata", reg_wdata_o, 32'd5);
        check("x0 instret",    instret_o, ret_exp(64'd8));
        set_dbg(1'b1, 5'd0, 32'h77);
        @(negedge clk_i);
        idle();
        check("x0 dbg write", reg_write_o, 1'b0);
        check("x0 dbg ack",   dbg_ack_o,   1'b1);
        check("x0 dbg instret", instret_o, ret_exp(64'd8));

        // Asynchronous reset while HELD
        set_instr(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        set_dbg(1'b1, 5'd6, 32'h66);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        idle();
        check("arst write",   reg_write_o, 1'b0);
        check("arst waddr",   reg_waddr_o, 5'd0);
        check("arst wdata",   reg_wdata_o, 32'd0);
        check("arst ack",     dbg_ack_o,   1'b0);
        check("arst instret", instret_o,   64'd0);
        check("arst ready",   input_ready_o, 1'b1);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("arst dropped write", reg_write_o, 1'b0);
        check("arst dropped waddr", reg_waddr_o, 5'd0);

        // Randomized traffic against the model
        repeat (400) begin
            set_instr(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom);
            set_dbg(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), $urandom);
            @(negedge clk_i);
        end
        idle();
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
